// File: rtl/nf_host_if.sv
`default_nettype none
// ============================================================================
// Module   : nf_host_if
// Brief    : CPU register file and command sequencer for nand_flash_top.
//            Turns single-cycle CPU writes into a stable nfcr/address command
//            interface, tracks each operation until done or timeout, latches
//            status/id for readback and raises a maskable level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module nf_host_if #(
  parameter logic [23:0] TIMEOUT = 24'd2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [2:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic [7:0]  nfcr,
  output logic [31:0] nf_addr0,
  output logic [31:0] nf_addr1,
  input  logic        done,
  input  logic [7:0]  status,
  input  logic [31:0] id,
  output logic        irq
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] A_CMD     = 3'd0;
  localparam logic [2:0] A_ADDR0   = 3'd1;
  localparam logic [2:0] A_ADDR1   = 3'd2;
  localparam logic [2:0] A_STAT    = 3'd3;
  localparam logic [2:0] A_ID      = 3'd4;
  localparam logic [2:0] A_IRQ     = 3'd5;
  localparam logic [2:0] A_ELAPSED = 3'd6;

  logic [0:0]  state_q, state_d;
  logic [6:0]  op_q, op_d;
  logic        go_q, go_d;
  logic [31:0] addr0_q, addr0_d;
  logic [31:0] addr1_q, addr1_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] elapsed_q, elapsed_d;
  logic [7:0]  status_q, status_d;
  logic [31:0] id_q, id_d;
  logic [2:0]  irq_en_q, irq_en_d;
  logic [2:0]  flags_q, flags_d;     // {timeout, overrun, done}
  logic        done_dly_q, done_dly_d;
  logic [31:0] rdata_q, rdata_d;

  logic        busy;
  logic        wr_cmd, wr_addr0, wr_addr1, wr_irq;
  logic        go_req, done_edge, tmo_hit;

  assign wr_cmd   = cpu_wr && (cpu_addr == A_CMD);
  assign wr_addr0 = cpu_wr && (cpu_addr == A_ADDR0);
  assign wr_addr1 = cpu_wr && (cpu_addr == A_ADDR1);
  assign wr_irq   = cpu_wr && (cpu_addr == A_IRQ);

  assign go_req   = wr_cmd && cpu_wdata[7] && !busy;
  // The first RUN cycle (counter still 0) never completes, so a done level
  // carried over from before the go cannot end the operation instantly.
  assign done_edge = busy && done && !done_dly_q && (cnt_q != 24'd0);
  // A simultaneous done edge takes priority over the terminal count.
  assign tmo_hit   = busy && (cnt_q == (TIMEOUT - 24'd1)) && !done_edge;

  // Operation state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: launch on go, return to idle on completion or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go_req) state_d = ST_RUN;
      ST_RUN:  if (done_edge || tmo_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs derived from state and held registers.
  always_comb begin
    busy     = (state_q == ST_RUN);
    nfcr     = {go_q, op_q};
    nf_addr0 = addr0_q;
    nf_addr1 = addr1_q;
    irq      = |(flags_q & irq_en_q);
  end

  assign cpu_rdata = rdata_q;

  // Register file, counter, capture and flag update.
  always_comb begin
    op_d       = op_q;
    go_d       = go_req;
    addr0_d    = addr0_q;
    addr1_d    = addr1_q;
    cnt_d      = cnt_q;
    elapsed_d  = elapsed_q;
    status_d   = status_q;
    id_d       = id_q;
    irq_en_d   = irq_en_q;
    done_dly_d = done;
    rdata_d    = rdata_q;

    // Command and addresses are frozen while an operation is in flight.
    if (wr_cmd && !busy)   op_d    = cpu_wdata[6:0];
    if (wr_addr0 && !busy) addr0_d = cpu_wdata;
    if (wr_addr1 && !busy) addr1_d = cpu_wdata;

    if (go_req)    cnt_d = 24'd0;
    else if (busy) cnt_d = cnt_q + 24'd1;

    if (done_edge) begin
      elapsed_d = cnt_q;
      status_d  = status;
      id_d      = id;
    end else if (tmo_hit) begin
      elapsed_d = TIMEOUT;
    end

    if (wr_irq) irq_en_d = cpu_wdata[2:0];

    // W1C clear first, then set, so a coincident set survives.
    flags_d = flags_q & ~({3{wr_irq}} & cpu_wdata[10:8]);
    flags_d = flags_d | {tmo_hit, wr_cmd && busy, done_edge};

    // Read mux samples the pre-write register contents.
    if (cpu_rd) begin
      case (cpu_addr)
        A_CMD:     rdata_d = {25'b0, op_q};
        A_ADDR0:   rdata_d = addr0_q;
        A_ADDR1:   rdata_d = addr1_q;
        A_STAT:    rdata_d = {16'b0, 4'b0, flags_q, busy, status_q};
        A_ID:      rdata_d = id_q;
        A_IRQ:     rdata_d = {21'b0, flags_q, 5'b0, irq_en_q};
        A_ELAPSED: rdata_d = {8'b0, elapsed_q};
        default:   rdata_d = 32'b0;
      endcase
    end
  end

  // Datapath registers; reset clears everything, dropping nfcr at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= 7'b0;
      go_q       <= 1'b0;
      addr0_q    <= 32'b0;
      addr1_q    <= 32'b0;
      cnt_q      <= 24'b0;
      elapsed_q  <= 24'b0;
      status_q   <= 8'b0;
      id_q       <= 32'b0;
      irq_en_q   <= 3'b0;
      flags_q    <= 3'b0;
      done_dly_q <= 1'b0;
      rdata_q    <= 32'b0;
    end else begin
      op_q       <= op_d;
      go_q       <= go_d;
      addr0_q    <= addr0_d;
      addr1_q    <= addr1_d;
      cnt_q      <= cnt_d;
      elapsed_q  <= elapsed_d;
      status_q   <= status_d;
      id_q       <= id_d;
      irq_en_q   <= irq_en_d;
      flags_q    <= flags_d;
      done_dly_q <= done_dly_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule
`default_nettype wire
